// File: rtl/key_word_gen.sv
// AES-128/192/256 key schedule generator.
// Streams w[0..Nw-1] one word per accepted transfer.
module key_word_gen #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        key_len,
  input  logic [255:0]      key_in,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        nk_q, nk_d;
  logic [255:0]      kbuf_q, kbuf_d;
  logic [WORD_W-1:0] hist_q [8];
  logic [WORD_W-1:0] hist_d [8];
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [2:0]        modc_q, modc_d;
  logic [7:0]        rcon_q, rcon_d;

  logic [WORD_W-1:0] h1 [8];
  logic [WORD_W-1:0] kw [8];
  logic [WORD_W-1:0] wnk, rot, sub_in, sub_out, t, nxt_word;
  logic [IDX_W-1:0]  nidx, last_idx;
  logic [2:0]        modn;
  logic [3:0]        nk_sel;
  logic              acc, is_last, rcon_step;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  assign acc       = valid_q & word_ready;
  assign last_idx  = IDX_W'({nk_q, 2'b00}) + IDX_W'(27);
  assign is_last   = (idx_q == last_idx);
  assign nidx      = idx_q + IDX_W'(1);
  assign modn      = ({1'b0, modc_q} == nk_q - 4'd1) ? 3'd0
                                                     : modc_q + 3'd1;
  assign rcon_step = (modc_q == 3'd0) && (idx_q >= IDX_W'(nk_q));

  // Key buffer split into words; history as seen after this accept.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      kw[j] = kbuf_q[255-32*j -: WORD_W];
    end
    h1[0] = word_q;
    for (int j = 1; j < 8; j++) begin
      h1[j] = hist_q[j-1];
    end
  end

  // Next schedule word computed from the shifted history.
  always_comb begin
    case (nk_q)
      4'd6:    wnk = h1[5];
      4'd8:    wnk = h1[7];
      default: wnk = h1[3];
    endcase
    rot     = {h1[0][23:0], h1[0][31:24]};
    sub_in  = (modn == 3'd0) ? rot : h1[0];
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
               sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (modn == 3'd0) begin
      t = sub_out ^ {rcon_q, {(WORD_W-8){1'b0}}};
    end else if (nk_q == 4'd8 && modn == 3'd4) begin
      t = sub_out;
    end else begin
      t = h1[0];
    end
    if (nidx < IDX_W'(nk_q)) begin
      nxt_word = kw[nidx[2:0]];
    end else begin
      nxt_word = wnk ^ t;
    end
  end

  // Key length decode; 2'b11 falls back to AES-128.
  always_comb begin
    case (key_len)
      2'b01:   nk_sel = 4'd6;
      2'b10:   nk_sel = 4'd8;
      default: nk_sel = 4'd4;
    endcase
  end

  // Control FSM and register next-state.
  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    kbuf_d  = kbuf_q;
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    modc_d  = modc_q;
    rcon_d  = rcon_q;
    for (int j = 0; j < 8; j++) begin
      hist_d[j] = hist_q[j];
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          nk_d    = nk_sel;
          kbuf_d  = key_in;
          word_d  = key_in[255 -: WORD_W];
          idx_d   = '0;
          valid_d = 1'b1;
          modc_d  = 3'd0;
          rcon_d  = 8'h01;
          for (int j = 0; j < 8; j++) begin
            hist_d[j] = '0;
          end
        end
      end
      S_RUN: begin
        if (acc) begin
          if (rcon_step) rcon_d = xtime(rcon_q);
          if (is_last) begin
            state_d = S_FIN;
            valid_d = 1'b0;
          end else begin
            word_d = nxt_word;
            idx_d  = nidx;
            modc_d = modn;
            for (int j = 0; j < 8; j++) begin
              hist_d[j] = h1[j];
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nk_q    <= 4'd4;
      kbuf_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      modc_q  <= 3'd0;
      rcon_q  <= 8'h00;
      for (int j = 0; j < 8; j++) begin
        hist_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      kbuf_q  <= kbuf_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      modc_q  <= modc_d;
      rcon_q  <= rcon_d;
      for (int j = 0; j < 8; j++) begin
        hist_q[j] <= hist_d[j];
      end
    end
  end

  assign word_out   = word_q;
  assign word_idx   = idx_q;
  assign word_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

endmodule

// File: tb/tb_key_word_gen.sv
// Bench for key_word_gen: known vectors, stalls,
// ignored restart, mid-run reset and random keys.
module tb_key_word_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [31:0]  word_out;
  logic [5:0]   word_idx;
  logic         word_valid;
  logic         word_ready;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  key_word_gen #(.WORD_W(32), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key_len(key_len), .key_in(key_in),
    .word_out(word_out), .word_idx(word_idx),
    .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  sb [256];
  logic [31:0] model_w [60];
  logic [31:0] got [60];
  int          model_nw;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [1:0]  kl;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box via exp/log tables over generator 3.
  task automatic init_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] x;
    logic [7:0] r;
    x = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = x;
      lg[x] = k;
      x = x ^ xt(x);
    end
    for (int v = 0; v < 256; v++) begin
      r = (v == 0) ? 8'h00 : ex[(255 - lg[v]) % 255];
      sb[v] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_model(input logic [1:0] kl,
                             input logic [255:0] key);
    int nk;
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [255:0] tmp;
    nk = (kl == 2'd1) ? 6 : (kl == 2'd2) ? 8 : 4;
    model_nw = 4 * nk + 28;
    rc = 8'h01;
    for (int i = 0; i < model_nw; i++) begin
      if (i < nk) begin
        tmp = key << (32 * i);
        model_w[i] = tmp[255:224];
      end else begin
        t = model_w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % 8 == 4) begin
          t = subw(t);
        end
        model_w[i] = model_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic run(input string tag, input logic [1:0] kl,
                     input logic [255:0] key, input int stall_pct,
                     input int restart_at, input int reset_at);
    logic [31:0] prev_w;
    logic [5:0]  prev_i;
    bit          stalled;
    bit          pulsed;
    int          cyc;
    int          n;
    int          done_cyc;
    stalled = 0;
    pulsed = 0;
    prev_w = '0;
    prev_i = '0;
    build_model(kl, key);
    @(negedge clk);
    start = 1'b1;
    key_len = kl;
    key_in = key;
    word_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    key_in = {8{$urandom()}};
    chk({tag, " first_valid"}, {word_valid, word_idx}, {1'b1, 6'd0});
    n = 0;
    cyc = 1;
    done_cyc = -1;
    while (cyc < 2000) begin
      if (reset_at >= 0 && n == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " reset_outs"},
            {word_valid, busy, done, word_out, word_idx}, 64'd0);
        repeat (3) @(negedge clk);
        chk({tag, " reset_hold"},
            {word_valid, busy, done, word_out, word_idx}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk({tag, " post_reset_idle"},
            {word_valid, busy, done}, 3'b000);
        return;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      chk({tag, " busy_valid"}, {busy, word_valid}, 2'b11);
      if (stalled) begin
        chk({tag, " stall_hold"}, {word_idx, word_out},
            {prev_i, prev_w});
      end
      if (restart_at >= 0 && n == restart_at && !pulsed) begin
        start = 1'b1;
        key_len = kl + 2'd1;
        key_in = ~key;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      word_ready = ($urandom_range(99) >= stall_pct);
      if (word_valid && word_ready) begin
        chk({tag, " idx"}, word_idx, n);
        chk({tag, " word"}, word_out, model_w[n]);
        if (n < 60) got[n] = word_out;
        n++;
        stalled = 0;
      end else begin
        stalled = word_valid;
        prev_w = word_out;
        prev_i = word_idx;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    word_ready = 1'b0;
    chk({tag, " done_seen"}, done_cyc >= 0, 1'b1);
    chk({tag, " accepts"}, n, model_nw);
    chk({tag, " done_state"}, {busy, word_valid}, 2'b10);
    if (stall_pct == 0) begin
      chk({tag, " done_cycle"}, done_cyc, model_nw + 1);
    end
    @(negedge clk);
    chk({tag, " done_pulse_end"}, {done, busy}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{2'd0, 4,  32'ha0fafe17};
    vecs[1] = '{2'd0, 43, 32'hb6630ca6};
    vecs[2] = '{2'd1, 6,  32'hfe0c91f7};
    vecs[3] = '{2'd1, 51, 32'h01002202};
    vecs[4] = '{2'd2, 8,  32'h9ba35411};
    vecs[5] = '{2'd2, 12, 32'ha8b09c1a};
    vecs[6] = '{2'd2, 59, 32'h706c631e};

    init_sbox();
    rst_n = 1'b0;
    start = 1'b0;
    key_len = 2'd0;
    key_in = '0;
    word_ready = 1'b0;
    #12;
    chk("reset_state",
        {word_valid, busy, done, word_out, word_idx}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      run($sformatf("kat%0d", r), 2'(r),
          (r == 0) ? K128 : (r == 1) ? K192 : K256, 0, -1, -1);
      for (int v = 0; v < 7; v++) begin
        if (vecs[v].kl == 2'(r)) begin
          chk($sformatf("vec_w%0d", vecs[v].idx),
              got[vecs[v].idx], vecs[v].exp);
        end
      end
    end

    run("stall50", 2'd0, K128, 50, -1, -1);
    chk("stall50_w43", got[43], 32'hb6630ca6);

    run("restart", 2'd0, K128, 0, 10, -1);
    chk("restart_w43", got[43], 32'hb6630ca6);

    run("abort", 2'd0, K128, 0, -1, 20);
    run("after_abort", 2'd0, K128, 0, -1, -1);
    chk("after_abort_w4", got[4], 32'ha0fafe17);

    for (int k = 0; k < 5; k++) begin
      run($sformatf("rand%0d", k), 2'($urandom_range(3)),
          {8{$urandom()}}, 30, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
